// File: rtl/mutative_reconfig_ctrl.sv
// Reconfiguration controller for the mutative cache.
//
// Accepts an associativity-mode change request, stalls the CPU side, waits for
// the cache to drain, then walks every (set, way) entry of the tag array in
// set-major order: dirty lines are written back and every line is invalidated.
// Finally the PLRU state is cleared and the new mode is driven on setup.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_req, cfg_mode     level request (held until cfg_ack) and requested mode
//   cfg_ack               one-cycle completion pulse
//   busy, cpu_stall       reconfiguration in progress / block CPU requests
//   setup                 current mode to cache datapath and PLRU block
//   cache_idle            cache has no outstanding miss/writeback
//   probe_en/set/way      tag array read strobe and walk address
//   probe_valid/dirty     probed entry state, one cycle after probe_en
//   wb_req, wb_ready      writeback handshake for (probe_set, probe_way)
//   inval_we              clear valid/dirty of (probe_set, probe_way)
//   plru_rst              one-cycle pulse clearing all PLRU bits
module mutative_reconfig_ctrl #(
    parameter int unsigned SET_SIZE     = 16,
    parameter int unsigned SET_IDX_BITS = 4,
    parameter int unsigned WAYS         = 8,
    parameter int unsigned WAY_IDX_BITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_req,
    input  logic [1:0]              cfg_mode,
    output logic                    cfg_ack,
    output logic                    busy,
    output logic [1:0]              setup,
    output logic                    cpu_stall,
    input  logic                    cache_idle,
    output logic                    probe_en,
    output logic [SET_IDX_BITS-1:0] probe_set,
    output logic [WAY_IDX_BITS-1:0] probe_way,
    input  logic                    probe_valid,
    input  logic                    probe_dirty,
    output logic                    wb_req,
    input  logic                    wb_ready,
    output logic                    inval_we,
    output logic                    plru_rst
);

    localparam int unsigned CntBits = SET_IDX_BITS + WAY_IDX_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StProbe,
        StCheck,
        StWb,
        StInval,
        StPlruClr,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         target_q, target_d;
    logic [1:0]         setup_q, setup_d;
    logic [CntBits-1:0] cnt_q, cnt_d;

    logic [SET_IDX_BITS-1:0] cur_set;
    logic [WAY_IDX_BITS-1:0] cur_way;
    logic                    last_entry;
    logic                    advance;
    logic                    walking;

    // Way index occupies the low bits so a plain increment walks set-major.
    assign cur_set    = cnt_q[CntBits-1:WAY_IDX_BITS];
    assign cur_way    = cnt_q[WAY_IDX_BITS-1:0];
    assign last_entry = (cur_set == SET_IDX_BITS'(SET_SIZE - 1)) &&
                        (cur_way == WAY_IDX_BITS'(WAYS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            target_q <= 2'b00;
            setup_q  <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            setup_q  <= setup_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        setup_d  = setup_q;
        cnt_d    = cnt_q;
        advance  = 1'b0;
        cfg_ack  = 1'b0;
        probe_en = 1'b0;
        wb_req   = 1'b0;
        inval_we = 1'b0;
        plru_rst = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_req) begin
                    target_d = cfg_mode;
                    // Same mode needs no flush: acknowledge directly.
                    state_d  = (cfg_mode == setup_q) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (cache_idle) begin
                    cnt_d   = '0;
                    state_d = StProbe;
                end
            end
            StProbe: begin
                probe_en = 1'b1;
                state_d  = StCheck;
            end
            StCheck: begin
                if (probe_valid && probe_dirty) begin
                    state_d = StWb;
                end else begin
                    // Clean or invalid lines are invalidated anyway: way mapping
                    // changes with the mode, so nothing may survive.
                    inval_we = 1'b1;
                    advance  = 1'b1;
                end
            end
            StWb: begin
                wb_req = 1'b1;
                if (wb_ready) begin
                    state_d = StInval;
                end
            end
            StInval: begin
                inval_we = 1'b1;
                advance  = 1'b1;
            end
            StPlruClr: begin
                plru_rst = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                cfg_ack = 1'b1;
                setup_d = target_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Completion is taken on the last entry, not on counter wrap.
        if (advance) begin
            if (last_entry) begin
                state_d = StPlruClr;
            end else begin
                cnt_d   = cnt_q + CntBits'(1);
                state_d = StProbe;
            end
        end
    end

    assign walking   = (state_q == StProbe) || (state_q == StCheck) ||
                       (state_q == StWb)    || (state_q == StInval);
    assign probe_set = walking ? cur_set : '0;
    assign probe_way = walking ? cur_way : '0;
    assign busy      = (state_q != StIdle);
    assign cpu_stall = busy;
    assign setup     = setup_q;

endmodule
